// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - LC-3b instruction fetch unit: FETCH/HOLD/FLUSH sequencer with PC redirect.
// Optional stall counter output enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [15:0] mem_address,
   output logic        mem_read,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [15:0] inst,
   output logic [3:0]  opcode,
   output logic [15:0] inst_pc,
   input  logic        pc_load,
`ifdef IFETCH_STALL_CNT_EN
   input  logic [15:0] pc_target,
   output logic [15:0] stall_cnt
`else
   input  logic [15:0] pc_target
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_pc;
   logic [15:0] w_pc_next;
   // Address of the read in flight; kept apart from r_pc so FLUSH can hold the stale address.
   logic [15:0] r_mem_addr;
   logic [15:0] w_mem_addr_next;
   logic [15:0] r_inst;
   logic [15:0] r_inst_pc;
   logic        w_capture;
   logic [15:0] w_target;

   assign w_target = pc_target & 16'hFFFE;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_capture    = 1'b0;
      case (r_state)
         FETCH: begin
            if (pc_load) begin
               w_pc_next    = w_target;
               w_state_next = mem_resp ? FETCH : FLUSH;
            end else if (mem_resp) begin
               w_capture    = 1'b1;
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (pc_load) begin
               w_pc_next    = w_target;
               w_state_next = FETCH;
            end else if (inst_ready) begin
               w_pc_next    = r_pc + 16'd2;
               w_state_next = FETCH;
            end
         end
         FLUSH: begin
            if (pc_load) begin
               w_pc_next = w_target;
            end
            // The stale response closes the outstanding read; only then may a new one start.
            if (mem_resp) begin
               w_state_next = FETCH;
            end
         end
         default: begin
            w_state_next = FETCH;
         end
      endcase
      w_mem_addr_next = (w_state_next == FETCH) ? w_pc_next : r_mem_addr;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC_ALIGNED;
         r_mem_addr <= RESET_PC_ALIGNED;
         r_inst     <= 16'h0000;
         r_inst_pc  <= 16'h0000;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_mem_addr <= w_mem_addr_next;
         if (w_capture) begin
            r_inst    <= mem_rdata;
            r_inst_pc <= r_mem_addr;
         end
      end
   end

   assign mem_read    = (r_state == FETCH) || (r_state == FLUSH);
   assign mem_address = r_mem_addr;
   assign inst_valid  = (r_state == HOLD);
   assign inst        = r_inst;
   assign inst_pc     = r_inst_pc;
   assign opcode      = r_inst[15:12];

`ifdef IFETCH_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_stall_cnt <= 16'h0000;
      end else if (inst_valid && !inst_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed vector bench for ifetch_unit (RESET_PC = 0).
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_address;
   logic        mem_read;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst;
   logic [3:0]  opcode;
   logic [15:0] inst_pc;
   logic        pc_load;
   logic [15:0] pc_target;
`ifdef IFETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_resp    (mem_resp),
      .mem_rdata   (mem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .opcode      (opcode),
      .inst_pc     (inst_pc),
      .pc_load     (pc_load),
`ifdef IFETCH_STALL_CNT_EN
      .pc_target   (pc_target),
      .stall_cnt   (stall_cnt)
`else
      .pc_target   (pc_target)
`endif
   );

   typedef struct {
      logic        ld;
      logic [15:0] tgt;
      logic        resp;
      logic [15:0] rdata;
      logic        ready;
      logic        e_mr;
      logic [15:0] e_addr;
      logic        e_iv;
      logic [15:0] e_inst;
      logic [15:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ld, input logic [15:0] tgt, input logic resp,
                      input logic [15:0] rdata, input logic ready, input logic e_mr,
                      input logic [15:0] e_addr, input logic e_iv,
                      input logic [15:0] e_inst, input logic [15:0] e_pc);
      vec_t v;
      v.ld = ld; v.tgt = tgt; v.resp = resp; v.rdata = rdata; v.ready = ready;
      v.e_mr = e_mr; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      int stall_model;
      logic [15:0] e_op;
      stall_model = 0;

      // ld tgt resp rdata ready | mr addr iv inst pc
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'h1042, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1042, 16'h0000);
      add(0, 16'h0000, 1, 16'h2002, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h2002, 16'h0002);
      add(0, 16'h0000, 1, 16'h5004, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h5004, 16'h0004);
      add(1, 16'h3001, 0, 16'h0000, 0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'hBAD0, 0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h3000, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'h1234, 0, 1, 16'h3000, 0, 16'h0000, 16'h0000);
      add(1, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234, 16'h3000);
      add(0, 16'h0000, 1, 16'hA0A0, 0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hA0A0, 16'hFFFE);
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'h0F0F, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 16'h4444, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0F0F, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 1, 16'h4444, 0, 16'h0000, 16'h0000);
      add(1, 16'h5555, 1, 16'hEEEE, 1, 1, 16'h4444, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h5554, 0, 16'h0000, 16'h0000);
      add(1, 16'h6000, 0, 16'h0000, 0, 1, 16'h5554, 0, 16'h0000, 16'h0000);
      add(1, 16'h7002, 0, 16'h0000, 0, 1, 16'h5554, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'hBBBB, 0, 1, 16'h5554, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 1, 16'hC0DE, 0, 1, 16'h7002, 0, 16'h0000, 16'h0000);
      add(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hC0DE, 16'h7002);

      reset_n = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0000; inst_ready = 1'b0;
      pc_load = 1'b0; pc_target = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_inst_valid", -1, {15'd0, inst_valid}, 16'h0000);
      chk("reset_inst", -1, inst, 16'h0000);
      chk("reset_inst_pc", -1, inst_pc, 16'h0000);
      chk("reset_opcode", -1, {12'd0, opcode}, 16'h0000);
`ifdef IFETCH_STALL_CNT_EN
      chk("reset_stall_cnt", -1, stall_cnt, 16'h0000);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         pc_load    = vecs[i].ld;
         pc_target  = vecs[i].tgt;
         mem_resp   = vecs[i].resp;
         mem_rdata  = vecs[i].rdata;
         inst_ready = vecs[i].ready;
         chk("mem_read", i, {15'd0, mem_read}, {15'd0, vecs[i].e_mr});
         chk("inst_valid", i, {15'd0, inst_valid}, {15'd0, vecs[i].e_iv});
         if (vecs[i].e_mr) chk("mem_address", i, mem_address, vecs[i].e_addr);
         if (vecs[i].e_iv) begin
            e_op = {12'd0, vecs[i].e_inst[15:12]};
            chk("inst", i, inst, vecs[i].e_inst);
            chk("inst_pc", i, inst_pc, vecs[i].e_pc);
            chk("opcode", i, {12'd0, opcode}, e_op);
         end
`ifdef IFETCH_STALL_CNT_EN
         chk("stall_cnt", i, stall_cnt, stall_model[15:0]);
`endif
         if (vecs[i].e_iv && !vecs[i].ready) stall_model++;
      end

      // Reset in the middle of a fetch, with a redirect pending at the same edge.
      @(negedge clk);
      chk("pre_reset_addr", 100, mem_address, 16'h7004);
      reset_n = 1'b0; pc_load = 1'b1; pc_target = 16'h1230; mem_resp = 1'b0;
      inst_ready = 1'b0;
      @(negedge clk);
      chk("rst_mid_addr", 101, mem_address, 16'h0000);
      chk("rst_mid_iv", 101, {15'd0, inst_valid}, 16'h0000);
      chk("rst_mid_inst", 101, inst, 16'h0000);
      reset_n = 1'b1; pc_load = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h3ABC;
      chk("post_rst_addr", 102, mem_address, 16'h0000);
      chk("post_rst_mr", 102, {15'd0, mem_read}, 16'h0001);
      @(negedge clk);
      mem_resp = 1'b0;
      chk("post_rst_iv", 103, {15'd0, inst_valid}, 16'h0001);
      chk("post_rst_inst", 103, inst, 16'h3ABC);
      chk("post_rst_inst_pc", 103, inst_pc, 16'h0000);
      chk("post_rst_opcode", 103, {12'd0, opcode}, 16'h0003);
`ifdef IFETCH_STALL_CNT_EN
      chk("post_rst_stall", 103, stall_cnt, 16'h0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
